xadac_vload: RTL and testbench

// - Vector load unit of the xadac coprocessor; the upstream counterpart of the activation/store stage.
// - Brings a VecDataT vector from memory into a vector register: accepts load instrs on xadac_if.slv,

---
 rtl/xadac_pkg.sv | 83 ++++++++
 rtl/xadac_if.sv | 32 +++
 rtl/xadac_sb_pick.sv | 29 ++
 rtl/xadac_vload.sv | 185 ++++++++++++++++++
 tb/tb_xadac_vload.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xadac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xadac_pkg
// Description : Shared widths, transaction structs and helpers for the xadac
//               coprocessor blocks (decode/execute handshakes, vector loads).
// Revision    : 1.0 - initial release
// ============================================================================
package xadac_pkg;

    localparam int SbLen        = 4;
    localparam int IdWidth      = $clog2(SbLen);
    localparam int AddrWidth    = 32;
    localparam int XlenWidth    = 32;
    localparam int InstrWidth   = 32;
    localparam int RegAddrWidth = 5;
    localparam int VecElemWidth = 8;
    localparam int VecLen       = 16;
    localparam int VecDataWidth = VecLen * VecElemWidth;
    localparam int VecLenWidth  = $clog2(VecLen + 1);

    typedef logic [IdWidth-1:0]      IdT;
    typedef logic [AddrWidth-1:0]    AddrT;
    typedef logic [XlenWidth-1:0]    XlenT;
    typedef logic [InstrWidth-1:0]   InstrT;
    typedef logic [RegAddrWidth-1:0] RegAddrT;
    typedef logic [VecDataWidth-1:0] VecDataT;
    typedef logic [VecLenWidth-1:0]  VecLenT;

    typedef struct packed {
        IdT    id;
        InstrT instr;
    } DecReqT;

    typedef struct packed {
        IdT         id;
        logic       accept;
        logic [1:0] rs_read;
        logic [2:0] vs_read;
        logic       rd_clobber;
        logic       vd_clobber;
    } DecRspT;

    typedef struct packed {
        IdT              id;
        InstrT           instr;
        logic [1:0][XlenWidth-1:0] rs_data;
    } ExeReqT;

    typedef struct packed {
        IdT      id;
        RegAddrT rd_addr;
        XlenT    rd_data;
        logic    rd_write;
        RegAddrT vd_addr;
        VecDataT vd_data;
        logic    vd_write;
    } ExeRspT;

    // One in-flight vector load: request fields, returned data and progress flags
    typedef struct packed {
        AddrT    addr;
        RegAddrT vd;
        VecLenT  vlen;
        VecDataT data;
        logic    valid;
        logic    ar_done;
        logic    r_done;
    } VLoadEntryT;

    // Zero every element at or beyond vlen
    function automatic VecDataT vec_mask(input VecDataT data, input VecLenT vlen);
        VecDataT res;
        res = data;
        for (int i = 0; i < VecLen; i++) begin
            if (i >= int'(vlen)) begin
                res[i*VecElemWidth +: VecElemWidth] = '0;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xadac_if.sv
`default_nettype none
// ============================================================================
// Module      : xadac_if
// Description : Decode and execute request/response channels between the
//               core and an xadac coprocessor unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface xadac_if;
    import xadac_pkg::*;

    logic   dec_req_valid;
    logic   dec_req_ready;
    DecReqT dec_req;
    logic   dec_rsp_valid;
    logic   dec_rsp_ready;
    DecRspT dec_rsp;

    logic   exe_req_valid;
    logic   exe_req_ready;
    ExeReqT exe_req;
    logic   exe_rsp_valid;
    logic   exe_rsp_ready;
    ExeRspT exe_rsp;

    modport slv (
        input  dec_req_valid, dec_req, dec_rsp_ready,
        output dec_req_ready, dec_rsp_valid, dec_rsp,
        input  exe_req_valid, exe_req, exe_rsp_ready,
        output exe_req_ready, exe_rsp_valid, exe_rsp
    );
endinterface
`default_nettype wire

// File: rtl/xadac_sb_pick.sv
`default_nettype none
// ============================================================================
// Module      : xadac_sb_pick
// Description : Lowest-index-first selector over scoreboard request bits.
// Revision    : 1.0 - initial release
// ============================================================================
module xadac_sb_pick #(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2
) (
    input  logic [ENTRIES-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xadac_vload.sv
`default_nettype none
// ============================================================================
// Module      : xadac_vload
// Description : Vector load unit. Accepts load instructions, issues AXI AR,
//               collects out-of-order R beats per ID and writes the vector
//               back through exe_rsp in lowest-ID-first order.
// Revision    : 1.0 - initial release
// ============================================================================
module xadac_vload
    import xadac_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    xadac_if.slv    slv,
    output IdT      axi_ar_id,
    output AddrT    axi_ar_addr,
    output logic    axi_ar_valid,
    input  logic    axi_ar_ready,
    input  IdT      axi_r_id,
    input  VecDataT axi_r_data,
    input  logic    axi_r_valid,
    output logic    axi_r_ready
);

    VLoadEntryT r_sb     [SbLen];
    VLoadEntryT w_sb_a   [SbLen];   // after exe_req write
    VLoadEntryT w_sb_nxt [SbLen];   // after AR, R and retire

    logic   r_ar_valid, w_ar_valid;
    IdT     r_ar_id,    w_ar_id;
    AddrT   r_ar_addr,  w_ar_addr;
    logic   r_r_ready;
    logic   r_rsp_valid, w_rsp_valid;
    ExeRspT r_rsp,       w_rsp;
    logic   r_beat_dropped, w_beat_dropped;   // pulses when an R beat matches no pending load

    logic             w_exe_req_hs;
    logic             w_r_hs;
    logic [SbLen-1:0] w_ar_req, w_rsp_req;
    IdT               w_ar_idx, w_rsp_idx;
    logic             w_ar_found, w_rsp_found;
    logic             w_unused_ok;

    assign w_unused_ok = ^{slv.dec_req.instr, slv.exe_req.rs_data[1],
                           slv.exe_req.instr[31:30], slv.exe_req.instr[24:12],
                           slv.exe_req.instr[6:0]};

    // Decode: every instruction routed here is a vector load reading rs1
    always_comb begin
        slv.dec_rsp_valid     = slv.dec_req_valid;
        slv.dec_req_ready     = slv.dec_req_valid && slv.dec_rsp_ready;
        slv.dec_rsp           = '0;
        slv.dec_rsp.id        = slv.dec_req.id;
        slv.dec_rsp.accept    = 1'b1;
        slv.dec_rsp.rs_read   = 2'b01;
        slv.dec_rsp.vd_clobber = 1'b1;
    end

    // An ID may only be reused once its previous load has retired
    assign w_exe_req_hs      = slv.exe_req_valid && !r_sb[slv.exe_req.id].valid;
    assign slv.exe_req_ready = w_exe_req_hs;
    assign w_r_hs            = axi_r_valid && r_r_ready;

    // Stage A: allocate the scoreboard entry for an accepted load
    always_comb begin
        w_sb_a = r_sb;
        if (w_exe_req_hs) begin
            w_sb_a[slv.exe_req.id]       = '0;
            w_sb_a[slv.exe_req.id].addr  = slv.exe_req.rs_data[0];
            w_sb_a[slv.exe_req.id].vd    = slv.exe_req.instr[11:7];
            w_sb_a[slv.exe_req.id].vlen  = slv.exe_req.instr[25 +: VecLenWidth];
            w_sb_a[slv.exe_req.id].valid = 1'b1;
        end
    end

    // AR candidates include an entry allocated this cycle
    always_comb begin
        for (int i = 0; i < SbLen; i++) begin
            w_ar_req[i] = w_sb_a[i].valid && !w_sb_a[i].ar_done;
        end
    end

    xadac_sb_pick #(
        .ENTRIES (SbLen),
        .IDX_W   (IdWidth)
    ) u_ar_pick (
        .req   (w_ar_req),
        .idx   (w_ar_idx),
        .found (w_ar_found)
    );

    // Stage B: AR issue, R capture, then retire of the handshaking response
    always_comb begin
        w_sb_nxt       = w_sb_a;
        w_ar_valid     = r_ar_valid && !axi_ar_ready;
        w_ar_id        = r_ar_id;
        w_ar_addr      = r_ar_addr;
        w_beat_dropped = 1'b0;

        if (!w_ar_valid && w_ar_found) begin
            w_ar_valid                 = 1'b1;
            w_ar_id                    = w_ar_idx;
            w_ar_addr                  = w_sb_a[w_ar_idx].addr;
            w_sb_nxt[w_ar_idx].ar_done = 1'b1;
        end

        if (w_r_hs) begin
            if (w_sb_a[axi_r_id].valid && w_sb_a[axi_r_id].ar_done && !w_sb_a[axi_r_id].r_done) begin
                w_sb_nxt[axi_r_id].data   = vec_mask(axi_r_data, w_sb_a[axi_r_id].vlen);
                w_sb_nxt[axi_r_id].r_done = 1'b1;
            end else begin
                w_beat_dropped = 1'b1;
            end
        end

        // Retire is applied before the response pick so a retiring entry is never re-presented
        if (r_rsp_valid && slv.exe_rsp_ready) begin
            w_sb_nxt[r_rsp.id] = '0;
        end
    end

    // Response candidates: any entry whose data has landed
    always_comb begin
        for (int i = 0; i < SbLen; i++) begin
            w_rsp_req[i] = w_sb_nxt[i].r_done;
        end
    end

    xadac_sb_pick #(
        .ENTRIES (SbLen),
        .IDX_W   (IdWidth)
    ) u_rsp_pick (
        .req   (w_rsp_req),
        .idx   (w_rsp_idx),
        .found (w_rsp_found)
    );

    // Stage C: hold the current response until accepted, else present the next one
    always_comb begin
        w_rsp_valid = r_rsp_valid && !slv.exe_rsp_ready;
        w_rsp       = r_rsp;
        if (!w_rsp_valid && w_rsp_found) begin
            w_rsp_valid      = 1'b1;
            w_rsp            = '0;
            w_rsp.id         = w_rsp_idx;
            w_rsp.vd_addr    = w_sb_nxt[w_rsp_idx].vd;
            w_rsp.vd_data    = w_sb_nxt[w_rsp_idx].data;
            w_rsp.vd_write   = 1'b1;
        end
    end

    // Scoreboard and registered AXI / response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SbLen; i++) begin
                r_sb[i] <= '0;
            end
            r_ar_valid     <= 1'b0;
            r_ar_id        <= '0;
            r_ar_addr      <= '0;
            r_r_ready      <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp          <= '0;
            r_beat_dropped <= 1'b0;
        end else begin
            r_sb           <= w_sb_nxt;
            r_ar_valid     <= w_ar_valid;
            r_ar_id        <= w_ar_id;
            r_ar_addr      <= w_ar_addr;
            r_r_ready      <= 1'b1;
            r_rsp_valid    <= w_rsp_valid;
            r_rsp          <= w_rsp;
            r_beat_dropped <= w_beat_dropped;
        end
    end

    assign axi_ar_valid      = r_ar_valid;
    assign axi_ar_id         = r_ar_id;
    assign axi_ar_addr       = r_ar_addr;
    assign axi_r_ready       = r_r_ready;
    assign slv.exe_rsp_valid = r_rsp_valid;
    assign slv.exe_rsp       = r_rsp;

endmodule
`default_nettype wire

// File: tb/tb_xadac_vload.sv
`default_nettype none
// ============================================================================
// Module      : tb_xadac_vload
// Description : Self-checking bench for the xadac vector load unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xadac_vload;
    import xadac_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    IdT      axi_ar_id;
    AddrT    axi_ar_addr;
    logic    axi_ar_valid;
    logic    axi_ar_ready;
    IdT      axi_r_id;
    VecDataT axi_r_data;
    logic    axi_r_valid;
    logic    axi_r_ready;

    xadac_if u_if ();

    xadac_vload dut (
        .clk          (clk),
        .rst          (rst),
        .slv          (u_if),
        .axi_ar_id    (axi_ar_id),
        .axi_ar_addr  (axi_ar_addr),
        .axi_ar_valid (axi_ar_valid),
        .axi_ar_ready (axi_ar_ready),
        .axi_r_id     (axi_r_id),
        .axi_r_data   (axi_r_data),
        .axi_r_valid  (axi_r_valid),
        .axi_r_ready  (axi_r_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic v;
        logic rr;
        IdT   id;
        logic exp_v;
        logic exp_r;
    } dec_vec_t;

    typedef struct packed {
        IdT      id;
        AddrT    addr;
        VecLenT  vlen;
        RegAddrT vd;
        VecDataT data;
        VecDataT exp;
    } load_vec_t;

    dec_vec_t  dec_tbl  [4];
    load_vec_t load_tbl [5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic InstrT mk_instr(input VecLenT vlen, input RegAddrT vd);
        return {2'b00, vlen, 13'b0, vd, 7'h0b};
    endfunction

    function automatic ExeRspT mk_rsp(input IdT id, input RegAddrT vd, input VecDataT data);
        ExeRspT r;
        r          = '0;
        r.id       = id;
        r.vd_addr  = vd;
        r.vd_data  = data;
        r.vd_write = 1'b1;
        return r;
    endfunction

    function automatic DecRspT mk_dec(input IdT id);
        DecRspT r;
        r            = '0;
        r.id         = id;
        r.accept     = 1'b1;
        r.rs_read    = 2'b01;
        r.vd_clobber = 1'b1;
        return r;
    endfunction

    // Byte b of the beat for id i is {i, b}
    function automatic VecDataT mk_data(input int i);
        VecDataT d;
        for (int b = 0; b < VecLen; b++) d[b*8 +: 8] = {4'(i), 4'(b)};
        return d;
    endfunction

    task automatic drive_req(input IdT id, input AddrT addr, input VecLenT vlen, input RegAddrT vd);
        u_if.exe_req_valid      = 1'b1;
        u_if.exe_req.id         = id;
        u_if.exe_req.instr      = mk_instr(vlen, vd);
        u_if.exe_req.rs_data[0] = addr;
        u_if.exe_req.rs_data[1] = 32'hDEAD_BEEF;
    endtask

    task automatic chk_rsp(input string name, input IdT id, input RegAddrT vd, input VecDataT data);
        chk({name, "_valid"}, 256'(u_if.exe_rsp_valid), 256'(1'b1));
        chk({name, "_rsp"}, 256'(u_if.exe_rsp), 256'(mk_rsp(id, vd, data)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst                = 1'b1;
        axi_ar_ready       = 1'b0;
        axi_r_valid        = 1'b0;
        axi_r_id           = '0;
        axi_r_data         = '0;
        u_if.dec_req_valid = 1'b0;
        u_if.dec_req       = '0;
        u_if.dec_rsp_ready = 1'b0;
        u_if.exe_req_valid = 1'b0;
        u_if.exe_req       = '0;
        u_if.exe_rsp_ready = 1'b0;

        dec_tbl[0] = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b1};
        dec_tbl[1] = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
        dec_tbl[2] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0};
        dec_tbl[3] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

        load_tbl[0] = '{2'd0, 32'h0000_1000, 5'd4, 5'd3,
                        128'h11223344_55667788_99AABBCC_DDCCBBAA,
                        128'h00000000_00000000_00000000_DDCCBBAA};
        load_tbl[1] = '{2'd2, 32'h0000_2040, 5'd16, 5'd17,
                        128'h01234567_89ABCDEF_FEDCBA98_76543210,
                        128'h01234567_89ABCDEF_FEDCBA98_76543210};
        load_tbl[2] = '{2'd1, 32'h0000_3000, 5'd0, 5'd31,
                        128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                        128'h0};
        load_tbl[3] = '{2'd3, 32'hFFFF_FFF0, 5'd9, 5'd8,
                        128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5,
                        128'h0000_0000_0000_00A5_A5A5_A5A5_A5A5_A5A5};
        load_tbl[4] = '{2'd1, 32'h0000_0044, 5'd1, 5'd1,
                        128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF7E,
                        128'h7E};

        // Reset state
        #1;
        chk("rst_ar_valid", 256'(axi_ar_valid), 256'(0));
        chk("rst_ar_addr", 256'(axi_ar_addr), 256'(0));
        chk("rst_r_ready", 256'(axi_r_ready), 256'(0));
        chk("rst_rsp_valid", 256'(u_if.exe_rsp_valid), 256'(0));
        chk("rst_rsp", 256'(u_if.exe_rsp), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_r_ready_first", 256'(axi_r_ready), 256'(0));
        @(negedge clk);
        chk("post_rst_r_ready", 256'(axi_r_ready), 256'(1));

        // Decode handshake table
        for (int i = 0; i < 4; i++) begin
            u_if.dec_req_valid = dec_tbl[i].v;
            u_if.dec_rsp_ready = dec_tbl[i].rr;
            u_if.dec_req.id    = dec_tbl[i].id;
            u_if.dec_req.instr = 32'h1234_5678;
            #1;
            chk("dec_rsp_valid", 256'(u_if.dec_rsp_valid), 256'(dec_tbl[i].exp_v));
            chk("dec_req_ready", 256'(u_if.dec_req_ready), 256'(dec_tbl[i].exp_r));
            chk("dec_rsp", 256'(u_if.dec_rsp), 256'(mk_dec(dec_tbl[i].id)));
            @(negedge clk);
        end
        u_if.dec_req_valid = 1'b0;

        // Single loads from the table
        for (int i = 0; i < 5; i++) begin
            drive_req(load_tbl[i].id, load_tbl[i].addr, load_tbl[i].vlen, load_tbl[i].vd);
            #1;
            chk("ld_req_ready", 256'(u_if.exe_req_ready), 256'(1));
            @(negedge clk);
            u_if.exe_req_valid = 1'b0;
            chk("ld_ar_valid", 256'(axi_ar_valid), 256'(1));
            chk("ld_ar_id", 256'(axi_ar_id), 256'(load_tbl[i].id));
            chk("ld_ar_addr", 256'(axi_ar_addr), 256'(load_tbl[i].addr));
            axi_ar_ready = 1'b1;
            @(negedge clk);
            axi_ar_ready = 1'b0;
            chk("ld_ar_drop", 256'(axi_ar_valid), 256'(0));
            chk("ld_rsp_early", 256'(u_if.exe_rsp_valid), 256'(0));
            axi_r_valid = 1'b1;
            axi_r_id    = load_tbl[i].id;
            axi_r_data  = load_tbl[i].data;
            @(negedge clk);
            axi_r_valid = 1'b0;
            chk_rsp("ld", load_tbl[i].id, load_tbl[i].vd, load_tbl[i].exp);
            u_if.exe_rsp_ready = 1'b1;
            @(negedge clk);
            u_if.exe_rsp_ready = 1'b0;
            chk("ld_rsp_drop", 256'(u_if.exe_rsp_valid), 256'(0));
        end

        // Out-of-order return and full scoreboard
        axi_ar_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(IdT'(i), 32'h100 * (i + 1), 5'd16, RegAddrT'(8 + i));
            #1;
            chk("ooo_req_ready", 256'(u_if.exe_req_ready), 256'(1));
            @(negedge clk);
        end
        u_if.exe_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ooo_ar_idle", 256'(axi_ar_valid), 256'(0));
        axi_ar_ready = 1'b0;
        drive_req(2'd1, 32'h900, 5'd2, 5'd20);
        #1;
        chk("full_ready_id1", 256'(u_if.exe_req_ready), 256'(0));
        u_if.exe_req.id = 2'd3;
        #1;
        chk("full_ready_id3", 256'(u_if.exe_req_ready), 256'(0));
        u_if.exe_req_valid = 1'b0;
        begin
            IdT r_order [4];
            r_order = '{2'd3, 2'd2, 2'd0, 2'd1};
            for (int k = 0; k < 4; k++) begin
                axi_r_valid = 1'b1;
                axi_r_id    = r_order[k];
                axi_r_data  = mk_data(int'(r_order[k]));
                @(negedge clk);
            end
        end
        axi_r_valid = 1'b0;
        chk_rsp("ooo_held3", 2'd3, 5'd11, mk_data(3));
        u_if.exe_rsp_ready = 1'b1;
        begin
            IdT rsp_order [4];
            rsp_order = '{2'd3, 2'd0, 2'd1, 2'd2};
            for (int k = 0; k < 4; k++) begin
                chk_rsp("ooo_rsp", rsp_order[k], RegAddrT'(8 + int'(rsp_order[k])),
                        mk_data(int'(rsp_order[k])));
                if (k == 2) begin
                    drive_req(2'd1, 32'h900, 5'd2, 5'd20);
                    #1;
                    chk("retire_same_cycle", 256'(u_if.exe_req_ready), 256'(0));
                end
                if (k == 3) begin
                    #1;
                    chk("retire_next_cycle", 256'(u_if.exe_req_ready), 256'(1));
                end
                @(negedge clk);
            end
        end
        u_if.exe_req_valid = 1'b0;
        chk("ooo_rsp_empty", 256'(u_if.exe_rsp_valid), 256'(0));
        chk("new1_ar_valid", 256'(axi_ar_valid), 256'(1));
        chk("new1_ar_id", 256'(axi_ar_id), 256'(1));
        chk("new1_ar_addr", 256'(axi_ar_addr), 256'(32'h900));
        axi_ar_ready = 1'b1;
        @(negedge clk);
        axi_ar_ready = 1'b0;
        axi_r_valid  = 1'b1;
        axi_r_id     = 2'd1;
        axi_r_data   = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        @(negedge clk);
        axi_r_valid = 1'b0;
        chk_rsp("new1", 2'd1, 5'd20, 128'h1100);
        @(negedge clk);
        u_if.exe_rsp_ready = 1'b0;
        chk("new1_rsp_drop", 256'(u_if.exe_rsp_valid), 256'(0));

        // Backpressure on AR and exe_rsp
        drive_req(2'd0, 32'h4000, 5'd16, 5'd1);
        @(negedge clk);
        drive_req(2'd1, 32'h5000, 5'd16, 5'd2);
        @(negedge clk);
        u_if.exe_req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_ar_valid", 256'(axi_ar_valid), 256'(1));
            chk("bp_ar_id", 256'(axi_ar_id), 256'(0));
            chk("bp_ar_addr", 256'(axi_ar_addr), 256'(32'h4000));
            @(negedge clk);
        end
        axi_ar_ready = 1'b1;
        @(negedge clk);
        chk("bp_ar2_id", 256'(axi_ar_id), 256'(1));
        chk("bp_ar2_addr", 256'(axi_ar_addr), 256'(32'h5000));
        @(negedge clk);
        axi_ar_ready = 1'b0;
        chk("bp_ar_empty", 256'(axi_ar_valid), 256'(0));
        axi_r_valid = 1'b1;
        axi_r_id    = 2'd1;
        axi_r_data  = mk_data(1);
        @(negedge clk);
        axi_r_id    = 2'd0;
        axi_r_data  = mk_data(0);
        @(negedge clk);
        axi_r_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_rsp("bp_hold", 2'd1, 5'd2, mk_data(1));
            @(negedge clk);
        end
        u_if.exe_rsp_ready = 1'b1;
        chk_rsp("bp_rsp1", 2'd1, 5'd2, mk_data(1));
        @(negedge clk);
        chk_rsp("bp_rsp0", 2'd0, 5'd1, mk_data(0));
        @(negedge clk);
        u_if.exe_rsp_ready = 1'b0;
        chk("bp_rsp_empty", 256'(u_if.exe_rsp_valid), 256'(0));

        // Unexpected beat on an idle ID
        axi_r_valid = 1'b1;
        axi_r_id    = 2'd3;
        axi_r_data  = mk_data(7);
        @(negedge clk);
        axi_r_valid = 1'b0;
        chk("unexp_flag", 256'(dut.r_beat_dropped), 256'(1));
        chk("unexp_no_rsp", 256'(u_if.exe_rsp_valid), 256'(0));
        @(negedge clk);
        chk("unexp_flag_clear", 256'(dut.r_beat_dropped), 256'(0));

        // Reset with two loads outstanding
        drive_req(2'd0, 32'h6000, 5'd16, 5'd4);
        @(negedge clk);
        drive_req(2'd2, 32'h7000, 5'd16, 5'd5);
        @(negedge clk);
        u_if.exe_req_valid = 1'b0;
        chk("mid_ar_valid_pre", 256'(axi_ar_valid), 256'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_ar_valid", 256'(axi_ar_valid), 256'(0));
        chk("mid_rst_ar_id", 256'(axi_ar_id), 256'(0));
        chk("mid_rst_ar_addr", 256'(axi_ar_addr), 256'(0));
        chk("mid_rst_r_ready", 256'(axi_r_ready), 256'(0));
        chk("mid_rst_rsp_valid", 256'(u_if.exe_rsp_valid), 256'(0));
        chk("mid_rst_rsp", 256'(u_if.exe_rsp), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_r_ready", 256'(axi_r_ready), 256'(1));
        axi_r_valid = 1'b1;
        axi_r_id    = 2'd0;
        axi_r_data  = mk_data(0);
        @(negedge clk);
        axi_r_valid = 1'b0;
        chk("late_beat_flag", 256'(dut.r_beat_dropped), 256'(1));
        chk("late_beat_no_rsp", 256'(u_if.exe_rsp_valid), 256'(0));
        drive_req(2'd0, 32'h6000, 5'd16, 5'd4);
        #1;
        chk("mid_id0_free", 256'(u_if.exe_req_ready), 256'(1));
        u_if.exe_req_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
